// File: rtl/arch_defs_pkg.sv
// arch_defs_pkg: shared architecture widths and RAM port arbiter types
package arch_defs_pkg;
  localparam int ADDR_WIDTH = 4;
  localparam int DATA_WIDTH = 8;
  localparam int ARB_LOCK_MAX_DEFAULT = 8;
  typedef enum logic [1:0] {ARB_IDLE, ARB_LOCK, ARB_LOCK_YIELD} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_LDR} arb_owner_t;
endpackage

// File: rtl/arb_rr_pick.sv
// arb_rr_pick: two-way round-robin picker; on a tie the requester that did not own the last grant wins
module arb_rr_pick
  import arch_defs_pkg::*;
(
  input  logic       cpu_req_i,
  input  logic       ldr_req_i,
  input  logic [1:0] last_owner_i,
  output logic [1:0] winner_o
);
  always_comb
    winner_o = (cpu_req_i && (!ldr_req_i || last_owner_i == OWN_LDR)) ? OWN_CPU
             : ldr_req_i ? OWN_LDR : OWN_NONE;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port RAM between CPU and loader with round-robin,
// loader burst lock and a starvation guard that forces a CPU slot after LOCK_MAX locked grants.
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
  parameter int LOCK_MAX   = arch_defs_pkg::ARB_LOCK_MAX_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic                  cpu_gnt_o,
  output logic                  cpu_rvalid_o,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  input  logic                  ldr_req_i,
  input  logic                  ldr_we_i,
  input  logic [ADDR_WIDTH-1:0] ldr_addr_i,
  input  logic [DATA_WIDTH-1:0] ldr_wdata_i,
  input  logic                  ldr_lock_i,
  output logic                  ldr_gnt_o,
  output logic                  ldr_rvalid_o,
  output logic [DATA_WIDTH-1:0] ldr_rdata_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);
  import arch_defs_pkg::*;
  localparam int CW = $clog2(LOCK_MAX + 1);
  arb_state_t state_q, state_d;
  arb_owner_t last_owner_q, last_owner_d, rd_owner_q, rd_owner_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d, cnt_inc;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, cpu_rdata_q, ldr_rdata_q;
  logic [1:0] pick;
  logic cpu_win, ldr_win;

  arb_rr_pick u_pick (
    .cpu_req_i   (cpu_req_i),
    .ldr_req_i   (ldr_req_i),
    .last_owner_i(last_owner_q),
    .winner_o    (pick)
  );

  assign cnt_inc = lock_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    cpu_win    = 1'b0;
    ldr_win    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        cpu_win = pick == OWN_CPU;
        ldr_win = pick == OWN_LDR;
        if (ldr_win && ldr_lock_i) state_d = ARB_LOCK;
      end
      ARB_LOCK: begin
        if (ldr_lock_i && ldr_req_i) begin
          ldr_win = 1'b1;
          if (cpu_req_i) begin
            lock_cnt_d = cnt_inc;
            if (cnt_inc == CW'(LOCK_MAX)) begin
              lock_cnt_d = '0;
              state_d    = ARB_LOCK_YIELD;
            end
          end
        end else begin
          // lock release or absent loader: the CPU is served in this same cycle
          cpu_win = cpu_req_i;
          ldr_win = ldr_req_i && !cpu_req_i;
          if (!ldr_lock_i || cpu_req_i) state_d = ARB_IDLE;
        end
      end
      default: begin
        cpu_win = cpu_req_i;
        ldr_win = ldr_req_i && !cpu_req_i;
        state_d = ldr_lock_i ? ARB_LOCK : ARB_IDLE;
      end
    endcase
  end

  assign cpu_gnt_o    = cpu_win && reset;
  assign ldr_gnt_o    = ldr_win && reset;
  assign ram_we_o     = cpu_gnt_o ? cpu_we_i : (ldr_gnt_o && ldr_we_i);
  assign ram_addr_o   = cpu_gnt_o ? cpu_addr_i : ldr_gnt_o ? ldr_addr_i : addr_q;
  assign ram_wdata_o  = cpu_gnt_o ? cpu_wdata_i : ldr_gnt_o ? ldr_wdata_i : wdata_q;
  assign last_owner_d = cpu_gnt_o ? OWN_CPU : ldr_gnt_o ? OWN_LDR : last_owner_q;
  assign rd_owner_d   = (cpu_gnt_o && !cpu_we_i) ? OWN_CPU
                      : (ldr_gnt_o && !ldr_we_i) ? OWN_LDR : OWN_NONE;
  assign cpu_rvalid_o = rd_owner_q == OWN_CPU;
  assign ldr_rvalid_o = rd_owner_q == OWN_LDR;
  assign cpu_rdata_o  = cpu_rvalid_o ? ram_rdata_i : cpu_rdata_q;
  assign ldr_rdata_o  = ldr_rvalid_o ? ram_rdata_i : ldr_rdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= OWN_LDR;
      rd_owner_q   <= OWN_NONE;
      lock_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ldr_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      rd_owner_q   <= rd_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      addr_q       <= ram_addr_o;
      wdata_q      <= ram_wdata_o;
      cpu_rdata_q  <= cpu_rdata_o;
      ldr_rdata_q  <= ldr_rdata_o;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed stimulus, behavioural arbiter/RAM model checked every cycle
module tb_ram_port_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int LOCK_MAX = 8;
  logic clk = 1'b0;
  logic reset;
  logic cpu_req_i, cpu_we_i, ldr_req_i, ldr_we_i, ldr_lock_i;
  logic [AW-1:0] cpu_addr_i, ldr_addr_i;
  logic [DW-1:0] cpu_wdata_i, ldr_wdata_i;
  logic cpu_gnt_o, cpu_rvalid_o, ldr_gnt_o, ldr_rvalid_o, ram_we_o;
  logic [DW-1:0] cpu_rdata_o, ldr_rdata_o, ram_wdata_o, ram_rdata_i;
  logic [AW-1:0] ram_addr_o;
  int total = 0;
  int bad = 0;
  logic [DW-1:0] ram_mem [16];
  logic [DW-1:0] m_mem [16];
  logic m_locked, m_yield, m_last_ldr, pend_c, pend_l;
  int m_streak;
  logic [DW-1:0] pend_cd, pend_ld, m_crd, m_lrd, m_ram_wd;
  logic [AW-1:0] m_ram_addr;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
    .ldr_req_i(ldr_req_i), .ldr_we_i(ldr_we_i), .ldr_addr_i(ldr_addr_i), .ldr_wdata_i(ldr_wdata_i),
    .ldr_lock_i(ldr_lock_i), .ldr_gnt_o(ldr_gnt_o), .ldr_rvalid_o(ldr_rvalid_o), .ldr_rdata_o(ldr_rdata_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we_o) ram_mem[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= ram_mem[ram_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    m_locked = 0; m_yield = 0; m_last_ldr = 1; m_streak = 0;
    pend_c = 0; pend_l = 0; pend_cd = 0; pend_ld = 0;
    m_crd = 0; m_lrd = 0; m_ram_addr = 0; m_ram_wd = 0;
  endtask

  always @(negedge clk) begin
    logic e_cg, e_lg, e_we;
    if (!reset) begin
      m_clear();
      chk("rst_ctrl", {cpu_gnt_o, ldr_gnt_o, cpu_rvalid_o, ldr_rvalid_o, ram_we_o}, 0);
      chk("rst_data", {ram_addr_o, ram_wdata_o, cpu_rdata_o, ldr_rdata_o}, 0);
    end else begin
      e_cg = 0; e_lg = 0;
      if (m_locked && !m_yield && ldr_lock_i && ldr_req_i) e_lg = 1;
      else if (m_locked || m_yield) begin e_cg = cpu_req_i; e_lg = ldr_req_i && !cpu_req_i; end
      else if (cpu_req_i && ldr_req_i) begin e_cg = m_last_ldr; e_lg = !m_last_ldr; end
      else begin e_cg = cpu_req_i; e_lg = ldr_req_i; end
      e_we = e_cg ? cpu_we_i : (e_lg && ldr_we_i);
      if (e_cg) begin m_ram_addr = cpu_addr_i; m_ram_wd = cpu_wdata_i; end
      else if (e_lg) begin m_ram_addr = ldr_addr_i; m_ram_wd = ldr_wdata_i; end
      chk("gnt", {cpu_gnt_o, ldr_gnt_o}, {e_cg, e_lg});
      chk("ram", {ram_we_o, ram_addr_o, ram_wdata_o}, {e_we, m_ram_addr, m_ram_wd});
      if (pend_c) m_crd = pend_cd;
      if (pend_l) m_lrd = pend_ld;
      chk("cpu_rd", {cpu_rvalid_o, cpu_rdata_o}, {pend_c, m_crd});
      chk("ldr_rd", {ldr_rvalid_o, ldr_rdata_o}, {pend_l, m_lrd});
      pend_c = e_cg && !cpu_we_i; pend_cd = m_mem[cpu_addr_i];
      pend_l = e_lg && !ldr_we_i; pend_ld = m_mem[ldr_addr_i];
      if (e_we) m_mem[m_ram_addr] = m_ram_wd;
      if (e_cg) m_last_ldr = 0;
      if (e_lg) m_last_ldr = 1;
      if (m_yield) begin
        m_yield = 0;
        m_locked = ldr_lock_i;
      end else if (m_locked) begin
        if (ldr_lock_i && ldr_req_i) begin
          if (cpu_req_i) begin
            m_streak++;
            if (m_streak == LOCK_MAX) begin m_streak = 0; m_yield = 1; end
          end
        end else if (!ldr_lock_i || cpu_req_i) m_locked = 0;
      end else if (e_lg && ldr_lock_i) m_locked = 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req_i = req; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
  endtask

  task automatic set_ldr(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic lk);
    ldr_req_i = req; ldr_we_i = we; ldr_addr_i = a; ldr_wdata_i = d; ldr_lock_i = lk;
  endtask

  task automatic rst_pulse();
    step();
    reset = 0;
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0, 0);
    step();
    reset = 1;
  endtask

  initial begin
    reset = 0;
    set_cpu(0, 0, 0, 0);
    set_ldr(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 8'(i * 17);
      m_mem[i] = 8'(i * 17);
    end
    ram_mem[3] = 8'hFF;
    m_mem[3] = 8'hFF;
    repeat (3) @(posedge clk);
    #1 reset = 1;

    step(); set_cpu(1, 0, 3, 0);
    @(negedge clk); chk("cpu_only_gnt", {cpu_gnt_o, ldr_gnt_o}, 2'b10);
    step(); set_cpu(0, 0, 3, 0);
    @(negedge clk);
    chk("cpu_only_rv", {cpu_rvalid_o, cpu_rdata_o}, {1'b1, 8'hFF});
    chk("cpu_only_ldr", {ldr_gnt_o, ldr_rvalid_o, ldr_rdata_o}, 0);

    rst_pulse();
    set_cpu(1, 0, 1, 0); set_ldr(1, 0, 2, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("tie_gnt", {cpu_gnt_o, ldr_gnt_o}, (i % 2) ? 2'b01 : 2'b10);
      if (i > 0) chk("tie_rv", {cpu_rvalid_o, ldr_rvalid_o}, (i % 2) ? 2'b10 : 2'b01);
      step();
    end
    set_cpu(0, 0, 0, 0); set_ldr(0, 0, 0, 0, 0);
    @(negedge clk); chk("tie_last_rv", {ldr_rvalid_o, ldr_rdata_o}, {1'b1, 8'h22});

    for (int i = 0; i < 4; i++) begin
      step(); set_ldr(1, 1, AW'(i), DW'(i + 1), 1);
      @(negedge clk);
      chk("burst", {ldr_gnt_o, cpu_gnt_o, ram_we_o, ram_addr_o, ram_wdata_o}, {3'b101, AW'(i), DW'(i + 1)});
    end
    step(); set_ldr(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      set_cpu(1, 0, AW'(i), 0);
      @(negedge clk);
      chk("rb_gnt", cpu_gnt_o, 1'b1);
      if (i > 0) chk("readback", {cpu_rvalid_o, cpu_rdata_o}, {1'b1, DW'(i)});
      step();
    end
    set_cpu(0, 0, 0, 0);
    @(negedge clk); chk("readback", {cpu_rvalid_o, cpu_rdata_o}, {1'b1, 8'h04});

    rst_pulse();
    set_ldr(1, 1, 7, 8'hA5, 1);
    @(negedge clk); chk("lock_enter", {cpu_gnt_o, ldr_gnt_o}, 2'b01);
    step(); set_cpu(1, 0, 0, 0);
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("starve", {cpu_gnt_o, ldr_gnt_o}, (i == 8) ? 2'b10 : 2'b01);
      step();
    end
    ldr_lock_i = 0;
    @(negedge clk); chk("release_cpu", {cpu_gnt_o, ldr_gnt_o}, 2'b10);
    step();
    @(negedge clk); chk("release_idle", {cpu_gnt_o, ldr_gnt_o}, 2'b01);

    step(); set_ldr(0, 0, 0, 0, 0); set_cpu(1, 0, 5, 0);
    @(negedge clk); chk("mid_rst_gnt", cpu_gnt_o, 1'b1);
    #1 reset = 0;
    set_cpu(0, 0, 0, 0);
    @(negedge clk);
    chk("mid_rst_out", {cpu_rvalid_o, cpu_gnt_o, ldr_gnt_o, ram_we_o, cpu_rdata_o}, 0);
    step(); reset = 1;
    set_cpu(1, 0, 1, 0); set_ldr(1, 0, 2, 0, 0);
    @(negedge clk); chk("post_rst_tie", {cpu_gnt_o, ldr_gnt_o}, 2'b10);
    step(); set_cpu(0, 0, 0, 0); set_ldr(0, 0, 0, 0, 0);
    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
